action_table: RTL and testbench
===============================

# action_table

Downstream stage of the BV-based searcher. It takes the searcher's `{bid, countid}` match index and reads a per-rule action word from a programmable action RAM. It returns that word with a hit flag to the field extractor. A config port lets the control plane read, write, and clear entries, plus read statistics when enabled.

## Interface
- `depthTCAM`, default 6: index width is `depthTCAM+5`, giving 2^(depthTCAM+5) entries.
- `ACT_WIDTH`, default 64: action word width.
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-low.
- `index_valid`, input, 1: lookup request strobe from the searcher.
- `index`, input, depthTCAM+5: `{bid[4:0], countid[5:0]}`.
- `cfg_valid`, input, 1: config request.
- `cfg_ready`, output, 1: config request accepted when `cfg_valid & cfg_ready`.
- `cfg_op`, input, 2: 0 read, 1 write, 2 clear, 3 stats read.
- `cfg_addr`, input, depthTCAM+5: entry address.
- `cfg_wdata`, input, ACT_WIDTH: write data.
- `cfg_ack`, output, 1: one-cycle completion pulse.
- `cfg_rdata`, output, ACT_WIDTH: read data, valid with `cfg_ack`.
- `action_valid`, output, 1: lookup result strobe.
- `action_hit`, output, 1: entry valid and not a no-match.
- `action`, output, ACT_WIDTH: action word; 0 on miss.

## Operation
- Storage: action RAM plus a per-entry valid bit vector held in flops. Reset clears all valid bits in one cycle; RAM contents are not reset.
- Lookup: the index is registered and the RAM is read.
  - Hit when the entry's valid bit is 1 and `countid != 6'h3F`. The value `6'h3F` means the searcher found no match.
  - On miss, `action_hit=0` and `action=0`.
- Config FSM states are IDLE, RD, ACK.
  - `cfg_ready = (state==IDLE) & ~index_valid`. Lookups always win the RAM read port.
  - Write: RAM[addr] gets `cfg_wdata` and valid[addr] is set. Goes IDLE→ACK.
  - Clear: valid[addr] is cleared; RAM is untouched. Goes IDLE→ACK.
  - Read: IDLE→RD→ACK. `cfg_rdata` = RAM[addr]; valid state is not reported.
  - Stats read: IDLE→ACK (see Configuration).
  - ACK drives `cfg_ack=1` for one cycle, then returns to IDLE.
- Only one config operation is outstanding at a time. A new request can be accepted the cycle after `cfg_ack`.
- Write/lookup hazard: a write accepted in cycle T is visible to lookups issued in T+1 onward. A same-cycle collision cannot occur because of `cfg_ready`.
- Reset mid-operation: the FSM returns to IDLE, in-flight lookups and config operations are dropped, and no `cfg_ack` or `action_valid` is produced for them.

## Timing
- Reset values:
  - `cfg_ready`: 1 if `index_valid=0`.
  - `cfg_ack`, `action_valid`, `action_hit`: 0.
  - `cfg_rdata`, `action`: 0.
- Lookup latency: `index_valid` at cycle T gives `action_valid` at T+2. Throughput is one lookup per cycle, and back-to-back indices are preserved in order.
- Config latency from acceptance in cycle T:
  - Write, clear, and stats read: `cfg_ack` at T+1.
  - Read: `cfg_ack` at T+2.
- `index_valid` held high continuously starves config indefinitely. This is by design, since the searcher never issues back-to-back lookups beyond packet rate.

## Configuration
- Macro: `ACTION_TABLE_STATS_EN`.
- Defined:
  - Two 32-bit counters, `hit_cnt` and `miss_cnt`, count every `action_valid` output and saturate at 0xFFFFFFFF.
  - op 3 returns `hit_cnt` (`cfg_addr[0]=0`) or `miss_cnt` (`cfg_addr[0]=1`), zero-extended to ACT_WIDTH.
  - If `cfg_addr[1]=1`, the selected counter is cleared after the read. If an increment lands in the same cycle, the counter becomes 1.
- Undefined: no counters exist, and op 3 acks with `cfg_rdata=0`.

## Structure
- Package `action_table_pkg` holds:
  - opcode constants `OP_READ`, `OP_WRITE`, `OP_CLEAR`, `OP_STATS`;
  - `COUNTID_MISS = 6'h3F`;
  - the FSM state encoding;
  - width constants.
- Sub-module `action_ram`: simple dual-port RAM (one write port, one registered read port), `ACT_WIDTH` × 2^(depthTCAM+5).

## Test plan
- Write addr 0x045 = 0x1122334455667788, then `index=0x045` → at T+2, `action_valid=1`, `action_hit=1`, `action=0x1122334455667788`.
- Lookup `index=0x07F` (countid 0x3F) after writing that address → `action_hit=0`, `action=0`.
- Clear addr 0x045, then lookup 0x045 → `action_hit=0`. A subsequent cfg read of 0x045 still returns 0x1122334455667788.
- Hold `index_valid=1` for 4 cycles while `cfg_valid=1` (read) → `cfg_ready=0` for those 4 cycles. The read is accepted on the 5th cycle and acks 2 cycles later; 4 `action_valid` results arrive in order.
- Write at cycle T to 0x100 = 0xAA, then lookup 0x100 at T+1 → `action=0xAA`, hit.
- With `ACTION_TABLE_STATS_EN`: 3 hits and 2 misses, then op 3 with addr 0x2 → rdata 3 and `hit_cnt` cleared. Op 3 with addr 0x1 → rdata 2. Assert reset mid-read → no `cfg_ack`, and all entries miss afterwards.

Source files
------------

// File: rtl/action_table_pkg.sv
// action_table_pkg: shared constants, opcodes and FSM encoding for the action table.
package action_table_pkg;

  localparam int COUNTID_W = 6;
  localparam int BID_W     = 5;
  localparam int OP_W      = 2;
  localparam int STAT_W    = 32;

  // countid value the searcher emits when nothing matched
  localparam logic [COUNTID_W-1:0] COUNTID_MISS = 6'h3F;

  localparam logic [OP_W-1:0] OP_READ  = 2'd0;
  localparam logic [OP_W-1:0] OP_WRITE = 2'd1;
  localparam logic [OP_W-1:0] OP_CLEAR = 2'd2;
  localparam logic [OP_W-1:0] OP_STATS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_ACK  = 2'd2
  } cfg_state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/action_table_if.sv
// action_table_if: lookup and config bus between searcher/control plane and the action table.
interface action_table_if #(
  parameter int depthTCAM = 6,
  parameter int ACT_WIDTH = 64
);
  import action_table_pkg::*;

  localparam int IDX_W = depthTCAM + 5;

  logic                 index_valid;
  logic [IDX_W-1:0]     index;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [OP_W-1:0]      cfg_op;
  logic [IDX_W-1:0]     cfg_addr;
  logic [ACT_WIDTH-1:0] cfg_wdata;
  logic                 cfg_ack;
  logic [ACT_WIDTH-1:0] cfg_rdata;
  logic                 action_valid;
  logic                 action_hit;
  logic [ACT_WIDTH-1:0] action;

  modport master (
    output index_valid, index, cfg_valid, cfg_op, cfg_addr, cfg_wdata,
    input  cfg_ready, cfg_ack, cfg_rdata, action_valid, action_hit, action
  );

  modport slave (
    input  index_valid, index, cfg_valid, cfg_op, cfg_addr, cfg_wdata,
    output cfg_ready, cfg_ack, cfg_rdata, action_valid, action_hit, action
  );

endinterface

// File: rtl/action_ram.sv
// action_ram: simple dual-port RAM, one write port and one registered read port, no reset.
module action_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write when asked, read every cycle into the output register
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/action_table.sv
// action_table: maps a searcher match index to a programmable action word.
// Optional hit/miss statistics are built when ACTION_TABLE_STATS_EN is defined.
module action_table
  import action_table_pkg::*;
#(
  parameter int depthTCAM = 6,
  parameter int ACT_WIDTH = 64
) (
  input logic         clk,
  input logic         reset,
  action_table_if.slave bus
);

  localparam int IDX_W   = depthTCAM + 5;
  localparam int ENTRIES = 1 << IDX_W;

  cfg_state_t           state;
  logic [ENTRIES-1:0]   valid_q;
  logic                 cfg_accept;
  logic                 ram_we;
  logic [IDX_W-1:0]     ram_raddr;
  logic [ACT_WIDTH-1:0] ram_rdata;
  logic                 s1_valid;
  logic                 s1_entry_valid;
  logic                 s1_nomatch;
  logic                 s1_hit;
  logic [ACT_WIDTH-1:0] stats_rdata;

  // Lookups own the read port, so config is only taken on idle lookup cycles
  assign bus.cfg_ready = (state == ST_IDLE) & ~bus.index_valid;
  assign cfg_accept    = bus.cfg_valid & bus.cfg_ready;
  assign ram_we        = cfg_accept & (bus.cfg_op == OP_WRITE);
  assign ram_raddr     = bus.index_valid ? bus.index : bus.cfg_addr;
  assign s1_hit        = s1_valid & s1_entry_valid & ~s1_nomatch;

  action_ram #(
    .ADDR_W(IDX_W),
    .DATA_W(ACT_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(bus.cfg_addr),
    .wdata(bus.cfg_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Per-entry valid bits: set by write, cleared by clear, all wiped by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (ram_we) begin
      valid_q[bus.cfg_addr] <= 1'b1;
    end else if (cfg_accept && bus.cfg_op == OP_CLEAR) begin
      valid_q[bus.cfg_addr] <= 1'b0;
    end
  end

  // Two-stage lookup pipeline: capture index attributes alongside the RAM read, then qualify the data
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid         <= 1'b0;
      s1_entry_valid   <= 1'b0;
      s1_nomatch       <= 1'b0;
      bus.action_valid <= 1'b0;
      bus.action_hit   <= 1'b0;
      bus.action       <= '0;
    end else begin
      s1_valid         <= bus.index_valid;
      s1_entry_valid   <= valid_q[bus.index];
      s1_nomatch       <= (bus.index[COUNTID_W-1:0] == COUNTID_MISS);
      bus.action_valid <= s1_valid;
      bus.action_hit   <= s1_hit;
      bus.action       <= s1_hit ? ram_rdata : '0;
    end
  end

`ifdef ACTION_TABLE_STATS_EN
  logic [STAT_W-1:0] hit_cnt;
  logic [STAT_W-1:0] miss_cnt;
  logic              stats_rd;
  logic              clr_hit;
  logic              clr_miss;
  logic              miss_inc;

  assign stats_rd    = cfg_accept & (bus.cfg_op == OP_STATS);
  assign clr_hit     = stats_rd & bus.cfg_addr[1] & ~bus.cfg_addr[0];
  assign clr_miss    = stats_rd & bus.cfg_addr[1] & bus.cfg_addr[0];
  assign miss_inc    = s1_valid & ~s1_hit;
  assign stats_rdata = bus.cfg_addr[0] ? ACT_WIDTH'(miss_cnt) : ACT_WIDTH'(hit_cnt);

  // Saturating result counters; a clear racing an increment keeps the new event
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (clr_hit)      hit_cnt <= s1_hit ? STAT_W'(1) : '0;
      else if (s1_hit)  hit_cnt <= sat_inc(hit_cnt);
      if (clr_miss)       miss_cnt <= miss_inc ? STAT_W'(1) : '0;
      else if (miss_inc)  miss_cnt <= sat_inc(miss_cnt);
    end
  end
`else
  assign stats_rdata = '0;
`endif

  // Config FSM: one outstanding request, ack is a registered single-cycle pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      bus.cfg_ack   <= 1'b0;
      bus.cfg_rdata <= '0;
    end else begin
      bus.cfg_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_accept) begin
            if (bus.cfg_op == OP_READ) begin
              state <= ST_RD;
            end else begin
              state         <= ST_ACK;
              bus.cfg_ack   <= 1'b1;
              bus.cfg_rdata <= (bus.cfg_op == OP_STATS) ? stats_rdata : '0;
            end
          end
        end
        ST_RD: begin
          state         <= ST_ACK;
          bus.cfg_ack   <= 1'b1;
          bus.cfg_rdata <= ram_rdata;
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_action_table.sv
// tb_action_table: directed, table-driven bench for action_table.
// Stats expectations switch on ACTION_TABLE_STATS_EN.
module tb_action_table;
  import action_table_pkg::*;

  localparam int DEPTH = 6;
  localparam int AW    = 64;
  localparam int IW    = DEPTH + 5;

  localparam int K_WRITE = 0;
  localparam int K_CLEAR = 1;
  localparam int K_READ  = 2;
  localparam int K_LOOK  = 3;

  typedef struct {
    int            kind;
    logic [IW-1:0] addr;
    logic [AW-1:0] data;
    logic          exp_hit;
    logic [AW-1:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  // Free-running clock
  always #5 clk = ~clk;

  action_table_if #(.depthTCAM(DEPTH), .ACT_WIDTH(AW)) bus();

  action_table #(.depthTCAM(DEPTH), .ACT_WIDTH(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic vec_t mk(input int k, input logic [IW-1:0] a, input logic [AW-1:0] d,
                              input logic h, input logic [AW-1:0] e);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.exp_hit = h; v.exp_data = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [AW-1:0] actual, input logic [AW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic doLookup(input logic [IW-1:0] idx, input logic exp_hit, input logic [AW-1:0] exp_data,
                          input string name);
    @(posedge clk); #1;
    bus.index_valid = 1'b1; bus.index = idx; bus.cfg_valid = 1'b0;
    @(posedge clk); #1;
    bus.index_valid = 1'b0;
    @(negedge clk);
    checkOutput({name, "_early"}, 64'(bus.action_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({name, "_valid"}, 64'(bus.action_valid), 64'd1);
    checkOutput({name, "_hit"}, 64'(bus.action_hit), 64'(exp_hit));
    checkOutput({name, "_action"}, bus.action, exp_data);
  endtask

  task automatic doCfg(input logic [1:0] op, input logic [IW-1:0] addr, input logic [AW-1:0] wdata,
                       input logic chk_rdata, input logic [AW-1:0] exp_rdata, input string name);
    @(posedge clk); #1;
    bus.index_valid = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_op = op; bus.cfg_addr = addr; bus.cfg_wdata = wdata;
    @(negedge clk);
    checkOutput({name, "_ready"}, 64'(bus.cfg_ready), 64'd1);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    if (op == OP_READ) begin
      @(negedge clk);
      checkOutput({name, "_ack_early"}, 64'(bus.cfg_ack), 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput({name, "_ack"}, 64'(bus.cfg_ack), 64'd1);
    if (chk_rdata) checkOutput({name, "_rdata"}, bus.cfg_rdata, exp_rdata);
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    case (v.kind)
      K_WRITE: doCfg(OP_WRITE, v.addr, v.data, 1'b0, '0, name);
      K_CLEAR: doCfg(OP_CLEAR, v.addr, '0, 1'b0, '0, name);
      K_READ:  doCfg(OP_READ, v.addr, '0, 1'b1, v.exp_data, name);
      default: doLookup(v.addr, v.exp_hit, v.exp_data, name);
    endcase
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    reset = 1'b0; bus.index_valid = 1'b0; bus.cfg_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Hard stop in case something never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    logic [IW-1:0] sidx [4];
    logic          shit [4];
    logic [AW-1:0] sexp [4];
    logic [AW-1:0] exp_s [5];

    bus.index_valid = 1'b0; bus.index = '0;
    bus.cfg_valid = 1'b0; bus.cfg_op = OP_READ; bus.cfg_addr = '0; bus.cfg_wdata = '0;

    vecs.push_back(mk(K_LOOK,  11'h045, '0, 1'b0, '0));
    vecs.push_back(mk(K_WRITE, 11'h045, 64'h1122334455667788, 1'b0, '0));
    vecs.push_back(mk(K_LOOK,  11'h045, '0, 1'b1, 64'h1122334455667788));
    vecs.push_back(mk(K_WRITE, 11'h07F, 64'hDEADBEEFCAFEF00D, 1'b0, '0));
    vecs.push_back(mk(K_LOOK,  11'h07F, '0, 1'b0, '0));
    vecs.push_back(mk(K_READ,  11'h07F, '0, 1'b0, 64'hDEADBEEFCAFEF00D));
    vecs.push_back(mk(K_WRITE, 11'h3C0, 64'h0123456789ABCDEF, 1'b0, '0));
    vecs.push_back(mk(K_LOOK,  11'h3C0, '0, 1'b1, 64'h0123456789ABCDEF));
    vecs.push_back(mk(K_CLEAR, 11'h045, '0, 1'b0, '0));
    vecs.push_back(mk(K_LOOK,  11'h045, '0, 1'b0, '0));
    vecs.push_back(mk(K_READ,  11'h045, '0, 1'b0, 64'h1122334455667788));
    vecs.push_back(mk(K_LOOK,  11'h3C0, '0, 1'b1, 64'h0123456789ABCDEF));
    vecs.push_back(mk(K_WRITE, 11'h7BE, 64'hFFFF0000FFFF0000, 1'b0, '0));
    vecs.push_back(mk(K_LOOK,  11'h7BE, '0, 1'b1, 64'hFFFF0000FFFF0000));
    vecs.push_back(mk(K_LOOK,  11'h7FF, '0, 1'b0, '0));
    vecs.push_back(mk(K_WRITE, 11'h045, 64'h5555, 1'b0, '0));
    vecs.push_back(mk(K_LOOK,  11'h045, '0, 1'b1, 64'h5555));

    // Reset values
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    checkOutput("rst_cfg_ack", 64'(bus.cfg_ack), 64'd0);
    checkOutput("rst_action_valid", 64'(bus.action_valid), 64'd0);
    checkOutput("rst_action_hit", 64'(bus.action_hit), 64'd0);
    checkOutput("rst_cfg_rdata", bus.cfg_rdata, 64'd0);
    checkOutput("rst_action", bus.action, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Four lookups starve a pending read, which then goes in on the fifth cycle
    sidx[0] = 11'h045; shit[0] = 1'b1; sexp[0] = 64'h5555;
    sidx[1] = 11'h07F; shit[1] = 1'b0; sexp[1] = 64'h0;
    sidx[2] = 11'h3C0; shit[2] = 1'b1; sexp[2] = 64'h0123456789ABCDEF;
    sidx[3] = 11'h7BE; shit[3] = 1'b1; sexp[3] = 64'hFFFF0000FFFF0000;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      if (c < 4) begin
        bus.index_valid = 1'b1; bus.index = sidx[c];
      end else begin
        bus.index_valid = 1'b0;
      end
      bus.cfg_valid = (c < 5); bus.cfg_op = OP_READ; bus.cfg_addr = 11'h3C0;
      @(negedge clk);
      if (c < 5) checkOutput($sformatf("starve_ready_c%0d", c), 64'(bus.cfg_ready), 64'(c == 4));
      if (c >= 2 && c < 6) begin
        checkOutput($sformatf("starve_valid_c%0d", c), 64'(bus.action_valid), 64'd1);
        checkOutput($sformatf("starve_hit_c%0d", c), 64'(bus.action_hit), 64'(shit[c-2]));
        checkOutput($sformatf("starve_action_c%0d", c), bus.action, sexp[c-2]);
      end
      if (c >= 4) checkOutput($sformatf("starve_ack_c%0d", c), 64'(bus.cfg_ack), 64'(c == 6));
    end
    checkOutput("starve_rdata", bus.cfg_rdata, 64'h0123456789ABCDEF);
    checkOutput("starve_tail_valid", 64'(bus.action_valid), 64'd0);

    // A write is visible to a lookup issued on the very next cycle
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1; bus.cfg_op = OP_WRITE; bus.cfg_addr = 11'h100; bus.cfg_wdata = 64'hAA;
    @(negedge clk);
    checkOutput("fwd_ready", 64'(bus.cfg_ready), 64'd1);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0; bus.index_valid = 1'b1; bus.index = 11'h100;
    @(negedge clk);
    checkOutput("fwd_ack", 64'(bus.cfg_ack), 64'd1);
    @(posedge clk); #1;
    bus.index_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("fwd_valid", 64'(bus.action_valid), 64'd1);
    checkOutput("fwd_hit", 64'(bus.action_hit), 64'd1);
    checkOutput("fwd_action", bus.action, 64'hAA);

    // Reset during a config read and an in-flight lookup drops both
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1; bus.cfg_op = OP_READ; bus.cfg_addr = 11'h3C0;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0; bus.index_valid = 1'b1; bus.index = 11'h3C0; reset = 1'b0;
    @(posedge clk); #1;
    bus.index_valid = 1'b0; reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rstmid_ack_c%0d", c), 64'(bus.cfg_ack), 64'd0);
      checkOutput($sformatf("rstmid_valid_c%0d", c), 64'(bus.action_valid), 64'd0);
      @(posedge clk); #1;
    end
    applyStimulus(mk(K_LOOK, 11'h3C0, '0, 1'b0, '0), "rstmid_look0");
    applyStimulus(mk(K_LOOK, 11'h100, '0, 1'b0, '0), "rstmid_look1");
    applyStimulus(mk(K_LOOK, 11'h045, '0, 1'b0, '0), "rstmid_look2");

    // Statistics: three hits, two misses, then read and clear counters
    doReset();
    applyStimulus(mk(K_WRITE, 11'h010, 64'h10, 1'b0, '0), "st_w0");
    applyStimulus(mk(K_WRITE, 11'h011, 64'h11, 1'b0, '0), "st_w1");
    applyStimulus(mk(K_WRITE, 11'h03F, 64'h33, 1'b0, '0), "st_w2");
    applyStimulus(mk(K_LOOK, 11'h010, '0, 1'b1, 64'h10), "st_l0");
    applyStimulus(mk(K_LOOK, 11'h011, '0, 1'b1, 64'h11), "st_l1");
    applyStimulus(mk(K_LOOK, 11'h010, '0, 1'b1, 64'h10), "st_l2");
    applyStimulus(mk(K_LOOK, 11'h012, '0, 1'b0, '0), "st_l3");
    applyStimulus(mk(K_LOOK, 11'h03F, '0, 1'b0, '0), "st_l4");
`ifdef ACTION_TABLE_STATS_EN
    exp_s[0] = 64'd3; exp_s[1] = 64'd0; exp_s[2] = 64'd2; exp_s[3] = 64'd2; exp_s[4] = 64'd0;
`else
    exp_s[0] = 64'd0; exp_s[1] = 64'd0; exp_s[2] = 64'd0; exp_s[3] = 64'd0; exp_s[4] = 64'd0;
`endif
    doCfg(OP_STATS, 11'h002, '0, 1'b1, exp_s[0], "st_hit_clr");
    doCfg(OP_STATS, 11'h000, '0, 1'b1, exp_s[1], "st_hit_after");
    doCfg(OP_STATS, 11'h001, '0, 1'b1, exp_s[2], "st_miss");
    doCfg(OP_STATS, 11'h003, '0, 1'b1, exp_s[3], "st_miss_clr");
    doCfg(OP_STATS, 11'h001, '0, 1'b1, exp_s[4], "st_miss_after");

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
